// File: rtl/fifo_rd_packer_if.sv
// Bundle of FIFO read-side and packed-output signals for fifo_rd_packer.
// master: the packer itself; slave: the FIFO plus the downstream consumer.
interface fifo_rd_packer_if #(
   parameter int DATA_WIDTH = 2,
   parameter int PACK_RATIO = 4
);
   logic                                  i_rempty;
   logic [DATA_WIDTH-1:0]                 i_rdata;
   logic                                  o_rd;
   logic                                  i_flush;
   logic [DATA_WIDTH*PACK_RATIO-1:0]      o_data;
   logic [$clog2(PACK_RATIO+1)-1:0]       o_nwords;
   logic                                  o_valid;
   logic                                  i_ready;

   modport master (
      input  i_rempty, i_rdata, i_flush, i_ready,
      output o_rd, o_data, o_nwords, o_valid
   );

   modport slave (
      output i_rempty, i_rdata, i_flush, i_ready,
      input  o_rd, o_data, o_nwords, o_valid
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// Packs PACK_RATIO show-ahead FIFO words LSB-first into one wide word on a valid/ready output.
// Optional idle auto-flush is enabled by defining PACKER_TIMEOUT_EN.
module fifo_rd_packer #(
   parameter int DATA_WIDTH     = 2,
   parameter int PACK_RATIO     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic             i_clk,
   input logic             i_rstn,
   fifo_rd_packer_if.master bus
);

   localparam int WW = DATA_WIDTH * PACK_RATIO;
   localparam int CW = $clog2(PACK_RATIO);
   localparam int NW = $clog2(PACK_RATIO + 1);

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   if (PACK_RATIO < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("fifo_rd_packer: PACK_RATIO must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WW-1:0]   data_q, data_d;
   logic [NW-1:0]   nwords_q, nwords_d;
   logic            valid_q, valid_d;

   logic            pop_s;
   logic            flush_s;
   logic [NW-1:0]   fill_s;

   // Reset gating keeps the FIFO untouched while the block is held in reset.
   assign pop_s  = i_rstn && !bus.i_rempty && ((state_q == COLLECT) || bus.i_ready);
   assign fill_s = NW'(cnt_q) + NW'(pop_s);

`ifdef PACKER_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

   logic [IW-1:0]   idle_q, idle_d;
   logic            timeout_s;

   // Idle counter: counts pop-free cycles while a partial word sits in COLLECT.
   always_comb begin
      idle_d    = idle_q;
      timeout_s = 1'b0;
      if ((state_q == COLLECT) && (cnt_q != '0) && !pop_s) begin
         if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
            timeout_s = 1'b1;
            idle_d    = '0;
         end else begin
            idle_d    = idle_q + IW'(1);
         end
      end else begin
         idle_d = '0;
      end
   end

   // Idle counter register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end

   assign flush_s = bus.i_flush || timeout_s;
`else
   assign flush_s = bus.i_flush;
`endif

   // Next-state and output computation for the COLLECT/HOLD machine.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      nwords_d = nwords_q;
      valid_d  = valid_q;
      case (state_q)
         COLLECT: begin
            if (pop_s) begin
               data_d[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] = bus.i_rdata;
            end else begin
               data_d = data_q;
            end
            if (pop_s && (cnt_q == CW'(PACK_RATIO - 1))) begin
               state_d  = HOLD;
               valid_d  = 1'b1;
               nwords_d = NW'(PACK_RATIO);
               cnt_d    = '0;
            end else if (flush_s && (fill_s != '0)) begin
               // Unfilled slots are already zero, so the partial word leaves as-is.
               state_d  = HOLD;
               valid_d  = 1'b1;
               nwords_d = fill_s;
               cnt_d    = '0;
            end else if (pop_s) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         HOLD: begin
            if (bus.i_ready) begin
               state_d  = COLLECT;
               valid_d  = 1'b0;
               nwords_d = '0;
               data_d   = '0;
               if (pop_s) begin
                  data_d[DATA_WIDTH-1:0] = bus.i_rdata;
                  cnt_d                  = CW'(1);
               end else begin
                  cnt_d = '0;
               end
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d  = COLLECT;
            cnt_d    = '0;
            data_d   = '0;
            nwords_d = '0;
            valid_d  = 1'b0;
         end
      endcase
   end

   // State and registered output update.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q  <= COLLECT;
         cnt_q    <= '0;
         data_q   <= '0;
         nwords_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         nwords_q <= nwords_d;
         valid_q  <= valid_d;
      end
   end

   assign bus.o_rd     = pop_s;
   assign bus.o_data   = data_q;
   assign bus.o_nwords = nwords_q;
   assign bus.o_valid  = valid_q;

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Read-side consumer of the team's independent-clocks FIFO, in the FIFO read clock domain. Pops narrow DATA_WIDTH words through a show-ahead interface (data valid whenever empty is low; a read pops) and packs PACK_RATIO of them, LSB-first, into one wide word. The wide word is presented downstream on a valid/ready handshake. Partial words can be emitted on request, zero-padded, with a fill count.

Parameters:
DATA_WIDTH, 2, width of each FIFO word.
PACK_RATIO, 4, FIFO words per output word (>=2).
TIMEOUT_CYCLES, 16, idle cycles before auto-flush (used only with PACKER_TIMEOUT_EN).

Ports:
i_clk  in  1  clock (FIFO read clock).
i_rstn  in  1  reset. Asynchronous, active-low.
i_rempty  in  1  FIFO empty flag.
i_rdata  in  DATA_WIDTH  FIFO head word, valid when i_rempty=0.
o_rd  out  1  FIFO pop strobe. Combinational.
i_flush  in  1  request emission of a partial word.
o_data  out  DATA_WIDTH*PACK_RATIO  packed word.
o_nwords  out  $clog2(PACK_RATIO+1)  number of filled slots in o_data.
o_valid  out  1  o_data/o_nwords valid.
i_ready  in  1  downstream accepts when o_valid && i_ready.

Behaviour:
- Reset values (asynchronous): state=COLLECT, slot count cnt=0, o_valid=0, o_data=0, o_nwords=0. o_rd is forced to 0 while i_rstn=0.
- States:
  - COLLECT: filling the word.
  - HOLD: o_valid=1, waiting for i_ready.
- o_rd = !i_rempty && (state==COLLECT || i_ready). Never pop when i_rempty=1.
- Pop in COLLECT:
  - i_rdata is written to o_data[cnt*DATA_WIDTH +: DATA_WIDTH] and cnt increments.
  - On the pop with cnt==PACK_RATIO-1: next state HOLD, o_valid=1 next cycle, o_nwords=PACK_RATIO, cnt=0.
- Latency: last word popped at cycle N gives o_valid=1 at cycle N+1.
- HOLD:
  - o_data and o_nwords are stable while o_valid && !i_ready.
  - On i_ready: o_valid drops next cycle unless the same cycle also popped and completed a new word (only possible for PACK_RATIO==1, which is not allowed). Return to COLLECT.
  - If o_rd is also high in that cycle, the popped word enters slot 0 of the new word, with the unused slots of the new word cleared. The new cnt=1.
- Handshake-cycle pop gives sustained throughput of PACK_RATIO pops per output word with no bubble.
- Flush:
  - i_flush in COLLECT with cnt>0 (after including any same-cycle pop): go to HOLD, unfilled slots=0, o_nwords=filled count.
  - If the same-cycle pop completes the word, normal full emission applies.
  - Flush with cnt==0 and no pop: ignored.
  - Flush in HOLD: ignored (not queued).
- o_data slots not written in the current word always read 0.
- Reset mid-word discards the partial word; no emission.

Optional Feature:
PACKER_TIMEOUT_EN.
- Defined:
  - An idle counter runs in COLLECT while cnt>0 and no pop occurs; it clears on pop or on leaving COLLECT.
  - On reaching TIMEOUT_CYCLES the block behaves exactly as if i_flush were asserted that cycle.
  - The counter resets to 0.
- Undefined: no counter logic; partial words leave only via i_flush.

Test Plan:
- Full word: FIFO supplies 2'b01,2'b10,2'b11,2'b00, i_ready=1 → o_data=8'b00111001, o_nwords=4, o_valid for 1 cycle, 4 o_rd pulses.
- Backpressure: full word presented with i_ready=0 for 5 cycles and FIFO non-empty → o_rd=0 throughout, o_data stable. Raising i_ready gives a pop in the same cycle into slot 0.
- Streaming: 12 words back-to-back, i_ready=1 → 3 output words with no bubble, 12 consecutive o_rd cycles after the first.
- Flush: pop 1,2,3 then i_flush → o_data=8'b00111001? No: 8'b00_11_10_01 with slot3=0 → 8'b00111001, o_nwords=3. Flush with cnt=0 → no o_valid.
- Reset mid-word: pop 2 words, pulse i_rstn low → o_valid=0, o_data=0. The next 4 words pack from slot 0.
- PACKER_TIMEOUT_EN, TIMEOUT_CYCLES=16: pop 1 word then empty → o_valid at the 16th idle cycle, o_nwords=1, o_data=8'b00000001 for word 2'b01.
